// File: rtl/sd_bd_fetch.sv
// sd_bd_fetch: consumer side of the SD buffer-descriptor queue.
// Reads each pending BD word by word, launches one block transfer, retires it.
module sd_bd_fetch #(
    parameter int DW     = 32,
    parameter int BD_W   = 8,
    parameter int MAX_BD = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic [BD_W-1:0] free_bd,
    output logic            re_s,
    input  logic            ack_o_s,
    input  logic [DW-1:0]   dat_in_s,
    output logic            a_cmp,
    output logic            start_o,
    output logic [31:0]     sys_addr_o,
    output logic [31:0]     blk_addr_o,
    input  logic            done_i,
    input  logic            err_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            clr_err_i,
    output logic [15:0]     bd_cnt_o
);

    localparam int WPB = 64 / DW;

    localparam logic [1:0] LAST_WC = 2'(WPB - 1);

    localparam logic [BD_W:0] MAX_W = (BD_W + 1)'(MAX_BD);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] REQ      = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] LAUNCH   = 3'd3;
    localparam logic [2:0] XFER     = 3'd4;
    localparam logic [2:0] RETIRE   = 3'd5;
    localparam logic [2:0] SETTLE   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [1:0]  wc_q, wc_d;
    logic [63:0] buf_q, buf_d;
    logic [31:0] sys_q, sys_d;
    logic [31:0] blk_q, blk_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic [BD_W:0] free_x;
    logic [BD_W:0] pending;
    logic          pend_nz;

    // Outstanding BDs; an out-of-range free count means nothing to fetch.
    always_comb begin
        free_x  = {1'b0, free_bd};
        pending = '0;
        if (free_x <= MAX_W) begin
            pending = MAX_W - free_x;
        end
        pend_nz = |pending;
    end

    // Next-state, word capture and address assembly.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        buf_d   = buf_q;
        sys_d   = sys_q;
        blk_d   = blk_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i && pend_nz) begin
                    state_d = REQ;
                    wc_d    = '0;
                end
            end
            REQ: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_o_s) begin
                    for (int i = 0; i < WPB; i++) begin
                        if (wc_q == 2'(i)) begin
                            buf_d[i*DW +: DW] = dat_in_s;
                        end
                    end
                    if (wc_q == LAST_WC) begin
                        state_d = LAUNCH;
                        sys_d   = buf_d[31:0];
                        blk_d   = buf_d[63:32];
                    end else begin
                        state_d = REQ;
                        wc_d    = wc_q + 2'd1;
                    end
                end
            end
            LAUNCH: begin
                state_d = XFER;
            end
            XFER: begin
                if (done_i) begin
                    state_d = RETIRE;
                end
            end
            RETIRE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error (capture beats clear) and retired-BD counter.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (state_q == XFER && done_i && err_i) begin
            err_d = 1'b1;
        end
        if (state_q == RETIRE) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wc_q    <= '0;
            buf_q   <= '0;
            sys_q   <= '0;
            blk_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            buf_q   <= buf_d;
            sys_q   <= sys_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign re_s       = (state_q == REQ);
    assign start_o    = (state_q == LAUNCH);
    assign a_cmp      = (state_q == RETIRE);
    assign busy_o     = (state_q != IDLE);
    assign sys_addr_o = sys_q;
    assign blk_addr_o = blk_q;
    assign err_o      = err_q;
    assign bd_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sd_bd_fetch.sv
// tb_sd_bd_fetch: directed bench for sd_bd_fetch.
// Drives a DW=32 and a DW=16 instance with hand-computed expectations.
module tb_sd_bd_fetch;

    logic        clk;
    logic        rst;
    logic        en32;
    logic        en16;
    logic [7:0]  free;
    logic        ack;
    logic [31:0] dat;
    logic        done;
    logic        err;
    logic        clr;

    logic        re32, acmp32, start32, busy32, erro32;
    logic [31:0] sys32, blk32;
    logic [15:0] cnt32;
    logic        re16, acmp16, start16, busy16, erro16;
    logic [31:0] sys16, blk16;
    logic [15:0] cnt16;

    int total = 0;
    int bad = 0;
    int n_re32 = 0;
    int n_re16 = 0;
    int n_ac32 = 0;
    int n_ac16 = 0;
    int e_cnt32 = 0;
    int e_cnt16 = 0;

    sd_bd_fetch #(.DW(32), .BD_W(8), .MAX_BD(64)) u32 (
        .clk(clk), .rst(rst), .enable_i(en32), .free_bd(free),
        .re_s(re32), .ack_o_s(ack), .dat_in_s(dat),
        .a_cmp(acmp32), .start_o(start32),
        .sys_addr_o(sys32), .blk_addr_o(blk32),
        .done_i(done), .err_i(err), .busy_o(busy32),
        .err_o(erro32), .clr_err_i(clr), .bd_cnt_o(cnt32)
    );

    sd_bd_fetch #(.DW(16), .BD_W(8), .MAX_BD(64)) u16 (
        .clk(clk), .rst(rst), .enable_i(en16), .free_bd(free),
        .re_s(re16), .ack_o_s(ack), .dat_in_s(dat[15:0]),
        .a_cmp(acmp16), .start_o(start16),
        .sys_addr_o(sys16), .blk_addr_o(blk16),
        .done_i(done), .err_i(err), .busy_o(busy16),
        .err_o(erro16), .clr_err_i(clr), .bd_cnt_o(cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (re32) n_re32++;
        if (re16) n_re16++;
        if (acmp32) n_ac32++;
        if (acmp16) n_ac16++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Wait for a strobe, then answer it after dly cycles.
    task automatic serve(input bit sel,
                         input logic [31:0] w,
                         input int dly);
        int n;
        n = 0;
        while (!(sel ? re16 : re32) && n < 30) begin
            tick();
            n++;
        end
        chk("re_seen", sel ? re16 : re32, 1);
        tick();
        for (int k = 0; k < dly; k++) begin
            chk("re_hold", sel ? re16 : re32, 0);
            tick();
        end
        ack = 1'b1;
        dat = w;
        tick();
        ack = 1'b0;
        dat = '0;
    endtask

    // From LAUNCH: run XFER, RETIRE, and stop in SETTLE.
    task automatic xfer(input bit sel, input bit e, input bit c);
        tick();
        chk("xfer_start", sel ? start16 : start32, 0);
        chk("xfer_busy", sel ? busy16 : busy32, 1);
        done = 1'b1;
        err = e;
        clr = c;
        tick();
        done = 1'b0;
        err = 1'b0;
        clr = 1'b0;
        chk("retire_acmp", sel ? acmp16 : acmp32, 1);
        if (sel) e_cnt16++;
        else e_cnt32++;
        tick();
        chk("settle_acmp", sel ? acmp16 : acmp32, 0);
        chk("bd_cnt", sel ? cnt16 : cnt32,
            sel ? 32'(e_cnt16) : 32'(e_cnt32));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en32 = 1'b0;
        en16 = 1'b0;
        free = 8'd64;
        ack = 1'b0;
        dat = '0;
        done = 1'b0;
        err = 1'b0;
        clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_re", re32, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_sys", sys32, 0);
        chk("rst_cnt", cnt32, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // single BD, DW=32
        free = 8'd63;
        en32 = 1'b1;
        serve(0, 32'h1000_0000, 0);
        chk("re_gap", re32, 1);
        serve(0, 32'h0000_0200, 0);
        chk("t1_start", start32, 1);
        chk("t1_sys", sys32, 32'h1000_0000);
        chk("t1_blk", blk32, 32'h0000_0200);
        xfer(0, 0, 0);
        free = 8'd64;
        chk("t1_nac", n_ac32, 1);
        repeat (6) tick();
        chk("t1_nre", n_re32, 2);
        chk("t1_idle", busy32, 0);

        // single BD, DW=16
        en32 = 1'b0;
        en16 = 1'b1;
        free = 8'd63;
        serve(1, 32'h0000, 0);
        serve(1, 32'h2000, 0);
        serve(1, 32'h0040, 0);
        serve(1, 32'h0000, 0);
        chk("t2_start", start16, 1);
        chk("t2_sys", sys16, 32'h2000_0000);
        chk("t2_blk", blk16, 32'h0000_0040);
        xfer(1, 0, 0);
        free = 8'd64;
        en16 = 1'b0;
        repeat (4) tick();
        chk("t2_nre", n_re16, 4);
        chk("t2_nac", n_ac16, 1);
        en32 = 1'b1;

        // two BDs back to back
        free = 8'd62;
        serve(0, 32'h0000_1111, 0);
        serve(0, 32'h0000_2222, 0);
        chk("t3a_sys", sys32, 32'h0000_1111);
        xfer(0, 0, 0);
        free = 8'd63;
        serve(0, 32'h0000_3333, 0);
        serve(0, 32'h0000_4444, 0);
        chk("t3b_blk", blk32, 32'h0000_4444);
        xfer(0, 0, 0);
        free = 8'd64;
        repeat (6) tick();
        chk("t3_nre", n_re32, 6);
        chk("t3_nac", n_ac32, 3);

        // delayed ack
        free = 8'd63;
        serve(0, 32'hAAAA_5555, 5);
        serve(0, 32'h1234_5678, 0);
        chk("t4_sys", sys32, 32'hAAAA_5555);
        chk("t4_blk", blk32, 32'h1234_5678);
        chk("t4_nre", n_re32, 8);
        xfer(0, 0, 0);
        free = 8'd64;
        tick();

        // error capture and clear
        free = 8'd63;
        serve(0, 32'h0, 0);
        serve(0, 32'h0, 0);
        xfer(0, 1, 0);
        free = 8'd64;
        chk("t5_err", erro32, 1);
        chk("t5_nac", n_ac32, 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr", erro32, 0);
        free = 8'd63;
        serve(0, 32'h0, 0);
        serve(0, 32'h0, 0);
        xfer(0, 1, 1);
        free = 8'd64;
        chk("t5_win", erro32, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr2", erro32, 0);

        // free count above capacity
        free = 8'd65;
        repeat (5) tick();
        chk("t6_over", n_re32, 12);
        chk("t6_obusy", busy32, 0);

        // reset during XFER
        free = 8'd63;
        serve(0, 32'h5555_0000, 0);
        serve(0, 32'h0000_0099, 0);
        tick();
        chk("t7_inxfer", busy32, 1);
        rst = 1'b0;
        #1;
        e_cnt32 = 0;
        chk("t7_re", re32, 0);
        chk("t7_acmp", acmp32, 0);
        chk("t7_start", start32, 0);
        chk("t7_sys", sys32, 0);
        chk("t7_blk", blk32, 0);
        chk("t7_busy", busy32, 0);
        chk("t7_err", erro32, 0);
        chk("t7_cnt", cnt32, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("t7_nac", n_ac32, 6);
        serve(0, 32'hCAFE_0000, 0);
        serve(0, 32'h0000_0077, 0);
        chk("t7_rsys", sys32, 32'hCAFE_0000);
        chk("t7_rblk", blk32, 32'h0000_0077);
        xfer(0, 0, 0);
        free = 8'd64;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
